// File: rtl/i2s_frame_ctrl.sv
// I2S master frame sequencer in the sclk domain: lrclk generation, one sample pair per frame.
// Define I2S_FRAME_CTRL_HOLD_ON_UNDERRUN_EN to repeat the last pair on underrun instead of sending silence.
module i2s_frame_ctrl #(
  parameter int AUDIO_DW = 32,
  parameter int LEN_W    = 6
) (
  input  logic                i_sclk,
  input  logic                i_rst,
  input  logic                i_enable,
  input  logic [LEN_W-1:0]    i_word_len,
  input  logic                i_s_valid,
  output logic                o_s_ready,
  input  logic [AUDIO_DW-1:0] i_s_left,
  input  logic [AUDIO_DW-1:0] i_s_right,
  output logic                o_lrclk,
  output logic [AUDIO_DW-1:0] o_tx_left,
  output logic [AUDIO_DW-1:0] o_tx_right,
  output logic                o_tx_load,
  output logic                o_rx_strobe,
  output logic                o_underrun,
  input  logic                i_underrun_clr,
  output logic                o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEFT,
    ST_RIGHT
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(AUDIO_DW);

  state_t              r_state;
  logic [LEN_W-1:0]    r_bit_cnt;
  logic [LEN_W-1:0]    r_len_q;
  logic                r_lrclk;
  logic [AUDIO_DW-1:0] r_tx_left;
  logic [AUDIO_DW-1:0] r_tx_right;
  logic                r_tx_load;
  logic                r_rx_strobe;
  logic                r_underrun;

  logic                w_slot_end;
  logic                w_fs;
  logic [LEN_W-1:0]    w_len_clamped;

  assign w_slot_end = (r_bit_cnt == (r_len_q - LEN_W'(1)));
  assign w_fs       = i_enable && ((r_state == ST_IDLE) ||
                                   ((r_state == ST_RIGHT) && w_slot_end));

  // A one-bit slot cannot carry a left/right alternation, so it is widened to two.
  always_comb begin
    w_len_clamped = i_word_len;
    if ((i_word_len == '0) || (i_word_len > MAX_LEN))
      w_len_clamped = MAX_LEN;
    else if (i_word_len == LEN_W'(1))
      w_len_clamped = LEN_W'(2);
  end

  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_lrclk     <= 1'b1;
      r_bit_cnt   <= '0;
      r_len_q     <= MAX_LEN;
      r_tx_left   <= '0;
      r_tx_right  <= '0;
      r_tx_load   <= 1'b0;
      r_rx_strobe <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_tx_load   <= w_fs;
      r_rx_strobe <= (r_state == ST_RIGHT) && w_slot_end;

      if (w_fs && !i_s_valid)
        r_underrun <= 1'b1;
      else if (i_underrun_clr)
        r_underrun <= 1'b0;

      if (w_fs) begin
        r_state   <= ST_LEFT;
        r_lrclk   <= 1'b0;
        r_bit_cnt <= '0;
        r_len_q   <= w_len_clamped;
        if (i_s_valid) begin
          r_tx_left  <= i_s_left;
          r_tx_right <= i_s_right;
        end else begin
`ifdef I2S_FRAME_CTRL_HOLD_ON_UNDERRUN_EN
          r_tx_left  <= r_tx_left;
          r_tx_right <= r_tx_right;
`else
          r_tx_left  <= '0;
          r_tx_right <= '0;
`endif
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_lrclk <= 1'b1;
          end
          ST_LEFT: begin
            if (w_slot_end) begin
              r_state   <= ST_RIGHT;
              r_lrclk   <= 1'b1;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + LEN_W'(1);
            end
          end
          ST_RIGHT: begin
            // Reaching the slot end here means enable is low: the frame closes into IDLE.
            if (w_slot_end) begin
              r_state   <= ST_IDLE;
              r_lrclk   <= 1'b1;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + LEN_W'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_lrclk <= 1'b1;
          end
        endcase
      end
    end
  end

  assign o_s_ready   = w_fs && !i_rst;
  assign o_lrclk     = r_lrclk;
  assign o_tx_left   = r_tx_left;
  assign o_tx_right  = r_tx_right;
  assign o_tx_load   = r_tx_load;
  assign o_rx_strobe = r_rx_strobe;
  assign o_underrun  = r_underrun;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Self-checking bench for i2s_frame_ctrl: directed scenarios plus a random run,
// compared every cycle against a frame-position model of the sequencer.
module tb_i2s_frame_ctrl;

  localparam int AUDIO_DW = 32;
  localparam int LEN_W    = 6;

  logic                sclk = 1'b0;
  logic                rst;
  logic                enable;
  logic [LEN_W-1:0]    wordLen;
  logic                sValid;
  logic                sReady;
  logic [AUDIO_DW-1:0] sLeft;
  logic [AUDIO_DW-1:0] sRight;
  logic                lrclk;
  logic [AUDIO_DW-1:0] txLeft;
  logic [AUDIO_DW-1:0] txRight;
  logic                txLoad;
  logic                rxStrobe;
  logic                underrun;
  logic                underrunClr;
  logic                busy;

  int total = 0;
  int bad   = 0;

  // The model tracks only "is a frame running" and the position inside it (0..2*len-1).
  bit                  mActive;
  int                  mPos;
  int                  mLen;
  logic [AUDIO_DW-1:0] mTxL;
  logic [AUDIO_DW-1:0] mTxR;
  bit                  mLoad;
  bit                  mStrobe;
  bit                  mUnder;

  int cycleNo    = 0;
  int lastReady  = -1;
  int lastGap    = 0;

  i2s_frame_ctrl #(.AUDIO_DW(AUDIO_DW), .LEN_W(LEN_W)) dut (
    .i_sclk         (sclk),
    .i_rst          (rst),
    .i_enable       (enable),
    .i_word_len     (wordLen),
    .i_s_valid      (sValid),
    .o_s_ready      (sReady),
    .i_s_left       (sLeft),
    .i_s_right      (sRight),
    .o_lrclk        (lrclk),
    .o_tx_left      (txLeft),
    .o_tx_right     (txRight),
    .o_tx_load      (txLoad),
    .o_rx_strobe    (rxStrobe),
    .o_underrun     (underrun),
    .i_underrun_clr (underrunClr),
    .o_busy         (busy)
  );

  always #5 sclk = ~sclk;

  function automatic int clampLen(input int w);
    if (w == 0 || w > AUDIO_DW) return AUDIO_DW;
    if (w == 1) return 2;
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mActive = 0;
    mPos    = 0;
    mLen    = AUDIO_DW;
    mTxL    = '0;
    mTxR    = '0;
    mLoad   = 0;
    mStrobe = 0;
    mUnder  = 0;
  endtask

  task automatic checkAll();
    checkOutput("lrclk",     {31'b0, lrclk},    {31'b0, (!mActive || mPos >= mLen)});
    checkOutput("tx_left",   txLeft,            mTxL);
    checkOutput("tx_right",  txRight,           mTxR);
    checkOutput("tx_load",   {31'b0, txLoad},   {31'b0, mLoad});
    checkOutput("rx_strobe", {31'b0, rxStrobe}, {31'b0, mStrobe});
    checkOutput("underrun",  {31'b0, underrun}, {31'b0, mUnder});
    checkOutput("busy",      {31'b0, busy},     {31'b0, mActive});
  endtask

  // Drive one cycle of inputs, check the handshake before the edge and all registers after it.
  task automatic applyStimulus(input bit en, input logic [LEN_W-1:0] wl, input bit v,
                               input logic [31:0] l, input logic [31:0] r, input bit clr);
    bit fs;
    @(negedge sclk);
    enable      = en;
    wordLen     = wl;
    sValid      = v;
    sLeft       = l;
    sRight      = r;
    underrunClr = clr;
    #1;
    fs = en && (!mActive || mPos == 2 * mLen - 1);
    checkOutput("s_ready", {31'b0, sReady}, {31'b0, fs});
    if (sReady) begin
      lastGap   = cycleNo - lastReady;
      lastReady = cycleNo;
    end
    cycleNo++;
    @(posedge sclk);
    if (fs) begin
      mStrobe = mActive;
      mActive = 1;
      mPos    = 0;
      mLen    = clampLen(int'(wl));
      mLoad   = 1;
      if (v) begin
        mTxL = l;
        mTxR = r;
      end else begin
`ifndef I2S_FRAME_CTRL_HOLD_ON_UNDERRUN_EN
        mTxL = '0;
        mTxR = '0;
`endif
      end
    end else begin
      mLoad   = 0;
      mStrobe = 0;
      if (mActive) begin
        if (mPos == 2 * mLen - 1) begin
          mActive = 0;
          mStrobe = 1;
        end else begin
          mPos++;
        end
      end
    end
    if (fs && !v) mUnder = 1;
    else if (clr) mUnder = 0;
    #1;
    checkAll();
  endtask

  task automatic goIdle();
    for (int i = 0; i < 100 && busy; i++)
      applyStimulus(0, 6'd4, 1, $urandom, $urandom, 0);
    checkOutput("go_idle", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; enable = 0; wordLen = '0; sValid = 0; sLeft = '0; sRight = '0; underrunClr = 0;
    modelReset();
    #1;
    checkAll();
    checkOutput("s_ready_rst", {31'b0, sReady}, 32'd0);
    @(negedge sclk);
    rst = 1'b0;

    $display("[TB] basic frame, word_len=16");
    for (int i = 0; i <= 40; i++) begin
      applyStimulus(1, 6'd16, 1, 32'h1111, 32'h2222, 0);
      if (i == 0) begin
        checkOutput("first_tx_left", txLeft, 32'h1111);
        checkOutput("first_tx_load", {31'b0, txLoad}, 32'd1);
      end
      if (i == 15) checkOutput("lrclk_left_end", {31'b0, lrclk}, 32'd0);
      if (i == 16) checkOutput("lrclk_right_start", {31'b0, lrclk}, 32'd1);
    end
    checkOutput("fs_gap_16", lastGap, 32'd32);

    $display("[TB] steady run, word_len=4");
    for (int i = 0; i < 50; i++)
      applyStimulus(1, 6'd4, 1, $urandom, $urandom, 0);
    checkOutput("fs_gap_4", lastGap, 32'd8);
    goIdle();

    $display("[TB] underrun at second frame start");
    for (int i = 0; i <= 9; i++) begin
      applyStimulus(1, 6'd4, (i != 8), (i == 0) ? 32'hAAAA : $urandom,
                    (i == 0) ? 32'hBBBB : $urandom, (i != 0));
      if (i == 8) begin
        checkOutput("underrun_set_wins", {31'b0, underrun}, 32'd1);
`ifdef I2S_FRAME_CTRL_HOLD_ON_UNDERRUN_EN
        checkOutput("underrun_tx_left", txLeft, 32'hAAAA);
`else
        checkOutput("underrun_tx_left", txLeft, 32'h0);
`endif
      end
      if (i == 9) checkOutput("underrun_cleared", {31'b0, underrun}, 32'd0);
    end
    goIdle();

    $display("[TB] enable dropped mid-LEFT, word_len=8");
    for (int i = 0; i <= 21; i++) begin
      applyStimulus((i <= 5), 6'd8, 1, $urandom, $urandom, 0);
      if (i == 16) begin
        checkOutput("drop_busy", {31'b0, busy}, 32'd0);
        checkOutput("drop_rx_strobe", {31'b0, rxStrobe}, 32'd1);
        checkOutput("drop_lrclk", {31'b0, lrclk}, 32'd1);
      end
    end

    $display("[TB] word_len change mid-frame");
    for (int i = 0; i <= 85; i++) begin
      applyStimulus(1, (i < 3) ? 6'd8 : ((i < 17) ? 6'd0 : 6'd1), 1, $urandom, $urandom, 0);
      if (i == 17) checkOutput("gap_len8", lastGap, 32'd16);
      if (i == 81) checkOutput("gap_len32", lastGap, 32'd64);
      if (i == 85) checkOutput("gap_len2", lastGap, 32'd4);
    end

    $display("[TB] asynchronous reset mid-RIGHT");
    for (int i = 0; i < 40 && !(mActive && mLen == 4 && mPos == mLen + 1); i++)
      applyStimulus(1, 6'd4, 1, $urandom, $urandom, 0);
    checkOutput("reached_right", {31'b0, busy && lrclk}, 32'd1);
    @(negedge sclk);
    enable = 1;
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkAll();
    checkOutput("s_ready_in_rst", {31'b0, sReady}, 32'd0);
    @(negedge sclk);
    @(negedge sclk);
    enable = 0;
    underrunClr = 0;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 6'd4, 1, $urandom, $urandom, 0);
      if (i == 0) checkOutput("restart_no_strobe", {31'b0, rxStrobe}, 32'd0);
    end

    $display("[TB] random run");
    for (int i = 0; i < 600; i++)
      applyStimulus(($urandom_range(0, 9) != 0), LEN_W'($urandom_range(0, 40)),
                    ($urandom_range(0, 4) != 0), $urandom, $urandom,
                    ($urandom_range(0, 9) == 0));
    goIdle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_frame_ctrl.md
Name: i2s_frame_ctrl

Overview:
I2S master frame sequencer running in the bit-clock (sclk) domain.
- Generates lrclk for the i2s transmitter and receiver.
- Pulls stereo samples from an upstream source through a valid/ready handshake, one pair per frame.
- Holds each pair stable for the transmitter, and emits a frame-complete strobe for receive-side capture.
- Sits between the audio sample FIFO and the i2s_tx/i2s_rx shift datapaths.

Parameters:
- AUDIO_DW, 32: maximum bits per channel slot; width of the sample buses.
- LEN_W, 6: width of the word_len port; must hold the value AUDIO_DW.

Ports:
- sclk  in  1  bit clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run request; sampled every cycle.
- word_len  in  LEN_W  bits per channel; latched at each frame start.
- s_valid  in  1  upstream sample pair valid.
- s_ready  out  1  upstream sample pair accepted this cycle.
- s_left  in  AUDIO_DW  upstream left sample.
- s_right  in  AUDIO_DW  upstream right sample.
- lrclk  out  1  word select: 0 = left slot, 1 = right slot.
- tx_left  out  AUDIO_DW  left sample for the current frame.
- tx_right  out  AUDIO_DW  right sample for the current frame.
- tx_load  out  1  one-cycle pulse: tx_left/tx_right were updated this cycle.
- rx_strobe  out  1  one-cycle pulse: a full left+right frame just completed.
- underrun  out  1  sticky: a frame start found s_valid low.
- underrun_clr  in  1  clears underrun.
- busy  out  1  high while not in IDLE.

Behaviour:
- Reset values (asynchronous): state IDLE, lrclk 1, bit_cnt 0, len_q AUDIO_DW, tx_left/tx_right 0, tx_load 0, rx_strobe 0, underrun 0. s_ready is combinational and is 0 in reset.
- States: IDLE, LEFT, RIGHT. bit_cnt counts 0..len_q-1 within each slot.
- Frame start (FS) is the cycle where either:
  - state is IDLE and enable=1, or
  - state is RIGHT, bit_cnt==len_q-1 and enable=1.
- s_ready = FS (combinational). A transfer occurs when s_ready && s_valid.
- At FS the next cycle state is LEFT, lrclk 0, bit_cnt 0, len_q latched from word_len, and tx_load pulses.
  - Transfer: tx_left/tx_right <= s_left/s_right.
  - No transfer: tx_left/tx_right <= 0 and underrun <= 1.
- LEFT, bit_cnt==len_q-1: next cycle state is RIGHT, lrclk 1, bit_cnt 0. Otherwise bit_cnt increments.
- RIGHT, bit_cnt==len_q-1, enable=0: next cycle state is IDLE, lrclk stays 1. A frame in progress always completes; enable is ignored mid-frame.
- rx_strobe pulses in the first LEFT cycle following a completed RIGHT slot, and in the cycle IDLE is entered from RIGHT. It never pulses on the first frame after IDLE.
- word_len clamp at latch: value 0 or value >AUDIO_DW gives AUDIO_DW; value 1 gives 2. A change mid-frame has no effect until the next FS.
- Frame period is 2*len_q sclk cycles; lrclk has a 50% duty cycle.
- underrun: set has priority over underrun_clr when both occur in the same cycle. Otherwise underrun_clr clears it.
- busy = (state != IDLE).
- Reset asserted mid-frame: immediate return to reset values. No partial handshake: s_ready is 0 during reset.

Optional Feature:
- Macro: I2S_FRAME_CTRL_HOLD_ON_UNDERRUN_EN.
- Defined: on underrun, tx_left/tx_right keep their previous values (last sample repeats); tx_load and underrun behave the same.
- Undefined: on underrun, tx_left/tx_right are loaded with 0 (silence).

Test Plan:
- Reset, then enable=1, word_len=16, s_valid=1 with L=0x1111, R=0x2222 -> s_ready high for 1 cycle; lrclk 0 for 16 cycles then 1 for 16; tx_left=0x1111; next FS 32 cycles after the first.
- Steady run, word_len=4, continuous valid -> lrclk period 8 cycles; s_ready every 8th cycle; rx_strobe coincides with every lrclk fall except the first.
- s_valid=0 at the second FS -> underrun=1; tx data is 0 (macro off) or a repeat of the previous pair (macro on); underrun_clr coincident with a new underrun leaves underrun=1.
- enable dropped at cycle 5 of LEFT, word_len=8 -> frame completes (16 cycles total), rx_strobe on IDLE entry, busy=0, lrclk=1, no further s_ready.
- word_len changed 8->0 mid-frame -> current frame stays at 8 bits; next frame uses 32 bits/slot. word_len=1 gives 2 bits/slot.
- rst pulsed asynchronously mid-RIGHT -> all outputs return to reset values immediately; after release with enable=1, the next frame starts cleanly with no rx_strobe.
